lane_delay_bank: RTL and testbench

//  Multi-lane programmable delay bank: LANES independent lanes, each a DEPTH-stage

---
 rtl/lane_delay_bank.sv | 134 +++++++++++++
 tb/tb_lane_delay_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_delay_bank.sv
`default_nettype none
// ============================================================================
// lane_delay_bank : per-lane tapped shift registers with phase inversion
//                   and a req/ack snapshot of all lane outputs.
// Revision 1.0
// ============================================================================
module lane_delay_bank #(
  parameter int                 LANES    = 4,
  parameter int                 WIDTH    = 1,
  parameter int                 DEPTH    = 4,
  parameter logic [LANES-1:0]   INV_MASK = 4'b1010,
  localparam int                DW       = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic [LANES*WIDTH-1:0] value_i,
  input  logic [DW-1:0]          cfg_delay,
  output logic [LANES*WIDTH-1:0] result_o,
  output logic                   result_valid,
  output logic [LANES*WIDTH-1:0] internal_o,
  input  logic                   snap_req,
  input  logic                   snap_ack,
  output logic                   snap_valid,
  output logic [LANES*WIDTH-1:0] snap_data,
  output logic                   snap_overrun
);

  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } snap_state_t;

  logic [DW-1:0] eff;
  logic [DW-1:0] cfg_q;
  logic [DW-1:0] fill;
  logic          cfg_chg;
  logic          phase;

  assign eff     = (cfg_delay > DEPTH_W) ? DEPTH_W : cfg_delay;
  assign cfg_chg = (cfg_delay != cfg_q);

  // A config change restarts the fill count so valid only returns once the
  // newly selected tap has been refilled with fresh data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
      fill  <= '0;
      phase <= 1'b0;
    end else begin
      cfg_q <= cfg_delay;
      phase <= ~phase;
      if (cfg_chg)
        fill <= '0;
      else if (en_i && (fill < DEPTH_W))
        fill <= fill + 1'b1;
    end
  end

  assign result_valid = (fill >= eff) && !cfg_chg;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] sr [DEPTH];
    logic [WIDTH-1:0] tap;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
      end else if (en_i) begin
        sr[0] <= value_i[l*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
    end

    // Zero delay bypasses the registers entirely.
    always_comb begin
      tap = value_i[l*WIDTH +: WIDTH];
      for (int k = 0; k < DEPTH; k++) begin
        if (eff == DW'(k + 1)) tap = sr[k];
      end
    end

    assign result_o[l*WIDTH +: WIDTH]   = tap ^ {WIDTH{phase & INV_MASK[l]}};
    assign internal_o[l*WIDTH +: WIDTH] = sr[0];
  end

  snap_state_t            snap_state_q, snap_state_d;
  logic [LANES*WIDTH-1:0] snap_data_q,  snap_data_d;
  logic                   overrun_q,    overrun_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_state_q <= IDLE;
      snap_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      snap_state_q <= snap_state_d;
      snap_data_q  <= snap_data_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    snap_state_d = snap_state_q;
    snap_data_d  = snap_data_q;
    overrun_d    = overrun_q;
    case (snap_state_q)
      IDLE: begin
        if (snap_req) begin
          snap_data_d  = result_o;
          snap_state_d = HELD;
        end
      end
      HELD: begin
        if (snap_ack && snap_req) begin
          snap_data_d = result_o;
        end else if (snap_ack) begin
          snap_state_d = IDLE;
        end else if (snap_req) begin
          overrun_d = 1'b1;
        end
      end
      default: snap_state_d = IDLE;
    endcase
  end

  assign snap_valid   = (snap_state_q == HELD);
  assign snap_data    = snap_data_q;
  assign snap_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_delay_bank.sv
`default_nettype none
// ============================================================================
// tb_lane_delay_bank : directed stimulus with a queued scoreboard checked by
//                      an independent monitor on the falling clock edge.
// Revision 1.0
// ============================================================================
module tb_lane_delay_bank;

  localparam int N = 4;

  localparam int ID_RES   = 0;
  localparam int ID_VALID = 1;
  localparam int ID_INT   = 2;
  localparam int ID_SV    = 3;
  localparam int ID_SD    = 4;
  localparam int ID_SO    = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_i;
  logic [N-1:0] value_i;
  logic [2:0]   cfg_delay;
  logic [N-1:0] result_o;
  logic         result_valid;
  logic [N-1:0] internal_o;
  logic         snap_req;
  logic         snap_ack;
  logic         snap_valid;
  logic [N-1:0] snap_data;
  logic         snap_overrun;

  lane_delay_bank dut (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_i),
    .value_i      (value_i),
    .cfg_delay    (cfg_delay),
    .result_o     (result_o),
    .result_valid (result_valid),
    .internal_o   (internal_o),
    .snap_req     (snap_req),
    .snap_ack     (snap_ack),
    .snap_valid   (snap_valid),
    .snap_data    (snap_data),
    .snap_overrun (snap_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  function automatic logic [31:0] actual(int id);
    case (id)
      ID_RES:   return 32'(result_o);
      ID_VALID: return 32'(result_valid);
      ID_INT:   return 32'(internal_o);
      ID_SV:    return 32'(snap_valid);
      ID_SD:    return 32'(snap_data);
      default:  return 32'(snap_overrun);
    endcase
  endfunction

  task automatic chk(int id, logic [31:0] val, string name);
    exp_t e;
    e.cyc  = cyc;
    e.id   = id;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes every expectation due at the current cycle.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          act = actual(sb[i].id);
          n_checks++;
          if (sb[i].cyc != cyc || act !== sb[i].val) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     sb[i].name, cyc, act, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    reset     = 1'b1;
    en_i      = 1'b1;
    cfg_delay = 3'd3;
    value_i   = '0;
    snap_req  = 1'b0;
    snap_ack  = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Test 1: delay 3, single pulse on lane 0
    value_i = 4'b0001;
    chk(ID_RES, 32'h0, "reset_result"); chk(ID_VALID, 32'h0, "reset_valid");
    chk(ID_INT, 32'h0, "reset_internal"); chk(ID_SV, 32'h0, "reset_snap_valid");
    chk(ID_SD, 32'h0, "reset_snap_data"); chk(ID_SO, 32'h0, "reset_overrun");
    step();                                                          // r+1
    value_i = 4'b0000;
    chk(ID_INT, 32'h1, "t1_internal_c1"); chk(ID_RES, 32'hA, "t1_res_c1");
    chk(ID_VALID, 32'h0, "t1_valid_c1");
    step();                                                          // r+2
    chk(ID_RES, 32'h0, "t1_res_c2"); chk(ID_INT, 32'h0, "t1_internal_c2");
    step();                                                          // r+3
    chk(ID_RES, 32'hB, "t1_res_c3_pulse"); chk(ID_VALID, 32'h0, "t1_valid_c3");
    step();                                                          // r+4
    chk(ID_RES, 32'h0, "t1_res_c4"); chk(ID_VALID, 32'h1, "t1_valid_c4");
    step();                                                          // r+5

    // Test 2: zero delay passes input through, lanes 1/3 follow phase
    cfg_delay = 3'd0; value_i = 4'b0000;
    chk(ID_RES, 32'hA, "t2_res_zero_in"); chk(ID_VALID, 32'h0, "t2_valid_chg");
    step();                                                          // r+6
    value_i = 4'b0101;
    chk(ID_RES, 32'h5, "t2_res_0101"); chk(ID_VALID, 32'h1, "t2_valid");
    step();                                                          // r+7
    value_i = 4'b0110;
    chk(ID_RES, 32'hC, "t2_res_0110_inv");
    step();                                                          // r+8

    // Test 3: delay 4, then freeze shifting for 5 cycles
    value_i = 4'b0001; cfg_delay = 3'd4;
    chk(ID_INT, 32'h6, "t3_internal_c8"); chk(ID_RES, 32'h0, "t3_res_c8");
    step();                                                          // r+9
    value_i = 4'b0010;
    chk(ID_VALID, 32'h0, "t3_valid_c9"); chk(ID_RES, 32'hA, "t3_res_c9");
    step();                                                          // r+10
    value_i = 4'b0011; en_i = 1'b0;
    chk(ID_RES, 32'h5, "t3_res_c10"); chk(ID_INT, 32'h2, "t3_internal_c10");
    step();                                                          // r+11
    chk(ID_RES, 32'hF, "t3_hold_res_c11"); chk(ID_INT, 32'h2, "t3_hold_int_c11");
    chk(ID_VALID, 32'h0, "t3_hold_valid_c11");
    step();                                                          // r+12
    chk(ID_RES, 32'h5, "t3_hold_res_c12"); chk(ID_INT, 32'h2, "t3_hold_int_c12");
    step();                                                          // r+13
    chk(ID_RES, 32'hF, "t3_hold_res_c13");
    step();                                                          // r+14
    chk(ID_RES, 32'h5, "t3_hold_res_c14"); chk(ID_VALID, 32'h0, "t3_hold_valid_c14");
    step();                                                          // r+15
    en_i = 1'b1; value_i = 4'b0000;
    chk(ID_RES, 32'hF, "t3_hold_res_c15"); chk(ID_INT, 32'h2, "t3_hold_int_c15");
    step();                                                          // r+16
    chk(ID_RES, 32'h6, "t3_resume_res"); chk(ID_INT, 32'h0, "t3_resume_int");
    chk(ID_VALID, 32'h0, "t3_resume_valid");
    step();                                                          // r+17
    chk(ID_VALID, 32'h0, "t3_fill3_valid");
    step();                                                          // r+18
    chk(ID_VALID, 32'h1, "t3_fill4_valid");
    step();                                                          // r+19

    // Test 4: delay 3 -> 1, then 7 saturating to 4
    cfg_delay = 3'd3;
    chk(ID_VALID, 32'h0, "t4_valid_chg3");
    step();                                                          // r+20
    cfg_delay = 3'd1; value_i = 4'b1001;
    chk(ID_VALID, 32'h0, "t4_valid_chg1");
    step();                                                          // r+21
    value_i = 4'b0100;
    chk(ID_VALID, 32'h0, "t4_valid_refill"); chk(ID_RES, 32'h3, "t4_res_d1_a");
    step();                                                          // r+22
    value_i = 4'b0000;
    chk(ID_VALID, 32'h1, "t4_valid_d1"); chk(ID_RES, 32'h4, "t4_res_d1_b");
    step();                                                          // r+23
    cfg_delay = 3'd7; value_i = 4'b1000;
    chk(ID_VALID, 32'h0, "t4_valid_chg7");
    step();                                                          // r+24
    value_i = 4'b0000;
    repeat (3) step();                                               // r+27

    // Test 5: snapshot capture, overrun, ack+req recapture
    snap_req = 1'b1;
    chk(ID_RES, 32'h2, "t4_res_d7_as_4"); chk(ID_VALID, 32'h0, "t4_valid_d7_fill3");
    step();                                                          // r+28
    snap_req = 1'b0;
    chk(ID_VALID, 32'h1, "t4_valid_d7_fill4");
    chk(ID_SV, 32'h1, "t5_snap_valid"); chk(ID_SD, 32'h2, "t5_snap_data");
    chk(ID_SO, 32'h0, "t5_no_overrun");
    step();                                                          // r+29
    snap_req = 1'b1;
    step();                                                          // r+30
    snap_ack = 1'b1;
    chk(ID_SV, 32'h1, "t5_ovr_valid"); chk(ID_SD, 32'h2, "t5_ovr_data_kept");
    chk(ID_SO, 32'h1, "t5_overrun");
    step();                                                          // r+31
    snap_ack = 1'b0; snap_req = 1'b0;
    chk(ID_SV, 32'h1, "t5_recap_valid"); chk(ID_SD, 32'h0, "t5_recap_data");
    chk(ID_SO, 32'h1, "t5_overrun_sticky");
    step();                                                          // r+32
    snap_ack = 1'b1;
    chk(ID_SV, 32'h1, "t5_hold_no_ack");
    step();                                                          // r+33
    chk(ID_SV, 32'h0, "t5_released");
    step();                                                          // r+34
    snap_ack = 1'b0; snap_req = 1'b1; value_i = 4'b1111;
    chk(ID_SV, 32'h0, "t5_ack_idle_ignored");
    step();                                                          // r+35

    // Test 6: reset while HELD with a full pipeline
    snap_req = 1'b0;
    chk(ID_SV, 32'h1, "t6_held");
    repeat (3) step();                                               // r+38
    reset = 1'b1;
    chk(ID_INT, 32'hF, "t6_full_int"); chk(ID_RES, 32'hF, "t6_full_res");
    chk(ID_SO, 32'h1, "t6_overrun_before");
    step();                                                          // r+39
    reset = 1'b0;
    chk(ID_RES, 32'h0, "t6_res"); chk(ID_INT, 32'h0, "t6_int");
    chk(ID_VALID, 32'h0, "t6_valid"); chk(ID_SV, 32'h0, "t6_snap_valid");
    chk(ID_SD, 32'h0, "t6_snap_data"); chk(ID_SO, 32'h0, "t6_overrun");
    step();
    step();

    foreach (sb[i]) begin
      n_fail++;
      $display("FAIL %s actual=unchecked required=%h", sb[i].name, sb[i].val);
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
